matrix_input_collector: RTL

//  Consumes the element stream from the UART command parser in INPUT mode: dim_m/dim_n, elem_data + write_en pulses, data_ready.

---
 rtl/matrix_input_collector.sv | 197 +++++++++++++++++++
 1 files changed

// File: rtl/matrix_input_collector.sv
// matrix_input_collector: validates the parser element stream and commits it row-major into a round-robin matrix slot
module matrix_input_collector #(
  parameter int MAX_DIM  = 5,
  parameter int ELEM_MAX = 9,
  parameter int SLOTS    = 4,
  parameter int SLOT_W   = 2,
  parameter int ADDR_W   = 7
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [2:0]        dim_m,
  input  logic [2:0]        dim_n,
  input  logic [7:0]        elem_data,
  input  logic              write_en,
  input  logic              data_ready,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              hdr_we,
  output logic [SLOT_W-1:0] hdr_slot,
  output logic [2:0]        hdr_m,
  output logic [2:0]        hdr_n,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              err_dim,
  output logic              err_val
);
  typedef enum logic [2:0] {IDLE, COLLECT, FILL, HDR, DONE, ERR} state_t;
  localparam logic [2:0]        DMAX = 3'(MAX_DIM);
  localparam logic [7:0]        EMAX = 8'(ELEM_MAX);
  localparam logic [ADDR_W-1:0] AREA = ADDR_W'(MAX_DIM * MAX_DIM);
  localparam logic [SLOT_W-1:0] LAST = SLOT_W'(SLOTS - 1);

  state_t            state_q, state_d;
  logic [SLOT_W-1:0] wr_ptr_q, wr_ptr_d, cur_slot_q, cur_slot_d, hdr_slot_q, hdr_slot_d;
  logic [5:0]        idx_q, idx_d, total_q, total_d;
  logic [2:0]        m_q, m_d, n_q, n_d, hdr_m_q, hdr_m_d, hdr_n_q, hdr_n_d;
  logic              dims_lat_q, dims_lat_d, mem_we_q, mem_we_d, hdr_we_q, hdr_we_d;
  logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
  logic              err_dim_q, err_dim_d, err_val_q, err_val_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d, slot_base;
  logic [7:0]        mem_wdata_q, mem_wdata_d;
  logic              dim_bad;

  assign slot_base = ADDR_W'(cur_slot_q) * AREA;
  assign dim_bad   = dim_m == 3'd0 || dim_n == 3'd0 || dim_m > DMAX || dim_n > DMAX;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    cur_slot_d  = cur_slot_q;
    idx_d       = idx_q;
    total_d     = total_q;
    m_d         = m_q;
    n_d         = n_q;
    dims_lat_d  = dims_lat_q;
    err_dim_d   = err_dim_q;
    err_val_d   = err_val_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    hdr_slot_d  = hdr_slot_q;
    hdr_m_d     = hdr_m_q;
    hdr_n_d     = hdr_n_q;
    mem_we_d    = 1'b0;
    hdr_we_d    = 1'b0;
    done_d      = 1'b0;
    err_d       = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d    = COLLECT;
        idx_d      = 6'd0;
        dims_lat_d = 1'b0;
        err_dim_d  = 1'b0;
        err_val_d  = 1'b0;
        cur_slot_d = wr_ptr_q;
      end
      COLLECT: begin
        // dims are captured on the first event so that event already sees them
        if (!dims_lat_q && (write_en || data_ready)) begin
          dims_lat_d = 1'b1;
          m_d        = dim_m;
          n_d        = dim_n;
          total_d    = 6'(dim_m) * 6'(dim_n);
          err_dim_d  = dim_bad;
        end
        if (write_en) begin
          if (elem_data > EMAX) err_val_d = 1'b1;
          else if (!err_dim_d && idx_q < total_d) begin
            mem_we_d    = 1'b1;
            mem_addr_d  = slot_base + ADDR_W'(idx_q);
            mem_wdata_d = elem_data;
            idx_d       = idx_q + 6'd1;
          end
        end
        if (data_ready)
          state_d = (err_dim_d || err_val_d) ? ERR : (idx_d < total_d) ? FILL : HDR;
      end
      FILL: begin
        mem_we_d    = 1'b1;
        mem_addr_d  = slot_base + ADDR_W'(idx_q);
        mem_wdata_d = 8'd0;
        idx_d       = idx_q + 6'd1;
        state_d     = (idx_q == total_q - 6'd1) ? HDR : FILL;
      end
      HDR: begin
        hdr_we_d   = 1'b1;
        hdr_slot_d = cur_slot_q;
        hdr_m_d    = m_q;
        hdr_n_d    = n_q;
        wr_ptr_d   = (wr_ptr_q == LAST) ? '0 : wr_ptr_q + 1'b1;
        state_d    = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        state_d = IDLE;
      end
      ERR: begin
        err_d   = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    if (abort) begin
      state_d   = IDLE;
      mem_we_d  = 1'b0;
      hdr_we_d  = 1'b0;
      done_d    = 1'b0;
      err_d     = 1'b0;
      wr_ptr_d  = wr_ptr_q;
      err_dim_d = err_dim_q;
      err_val_d = err_val_q;
    end
    busy_d = state_d != IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      cur_slot_q  <= '0;
      idx_q       <= '0;
      total_q     <= '0;
      m_q         <= '0;
      n_q         <= '0;
      dims_lat_q  <= 1'b0;
      err_dim_q   <= 1'b0;
      err_val_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      hdr_we_q    <= 1'b0;
      hdr_slot_q  <= '0;
      hdr_m_q     <= '0;
      hdr_n_q     <= '0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      cur_slot_q  <= cur_slot_d;
      idx_q       <= idx_d;
      total_q     <= total_d;
      m_q         <= m_d;
      n_q         <= n_d;
      dims_lat_q  <= dims_lat_d;
      err_dim_q   <= err_dim_d;
      err_val_q   <= err_val_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      hdr_we_q    <= hdr_we_d;
      hdr_slot_q  <= hdr_slot_d;
      hdr_m_q     <= hdr_m_d;
      hdr_n_q     <= hdr_n_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign hdr_we    = hdr_we_q;
  assign hdr_slot  = hdr_slot_q;
  assign hdr_m     = hdr_m_q;
  assign hdr_n     = hdr_n_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign err       = err_q;
  assign err_dim   = err_dim_q;
  assign err_val   = err_val_q;
endmodule
